stack_ctrl: RTL and testbench

//   Push-down stack (LIFO) controller driving an array of DEPTH words built from

---
 rtl/stack_ctrl.sv | 81 ++++++++
 tb/tb_stack_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO controller that drives a one-hot row-selected word array.
// Tracks the stack pointer and flags full/empty/error. Each push or pop takes one extra array cycle.
module stack_ctrl #(
  parameter int BUSWIDTH  = 8,
  parameter int DEPTH     = 16,
  parameter int ADDRWIDTH = 4
) (
  input  logic                Clk_i,
  input  logic                RstN_i,
  input  logic                Push_i,
  input  logic                Pop_i,
  input  logic [BUSWIDTH-1:0] data_i,
  output logic [BUSWIDTH-1:0] data_o,
  output logic                Valid_o,
  output logic                Busy_o,
  output logic                Full_o,
  output logic                Empty_o,
  output logic                Err_o,
  output logic [DEPTH-1:0]    RowSel_o,
  output logic                WEn_o,
  output logic [BUSWIDTH-1:0] MemData_o,
  input  logic [BUSWIDTH-1:0] MemData_i
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t               state;
  logic [ADDRWIDTH:0]   sp;
  logic [ADDRWIDTH-1:0] idx, idx_dec;
  logic                 reject;
  assign idx     = sp[ADDRWIDTH-1:0];
  assign idx_dec = idx - 1'b1;
  assign Busy_o  = state != IDLE;
  // DEPTH is 2**ADDRWIDTH and SP never exceeds DEPTH, so the top bit alone marks full
  assign Full_o  = sp[ADDRWIDTH];
  assign Empty_o = sp == '0;
  assign reject  = (Push_i && Pop_i) || (Push_i && Full_o) || (Pop_i && Empty_o);
  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      state     <= IDLE;
      sp        <= '0;
      RowSel_o  <= '0;
      WEn_o     <= 1'b0;
      MemData_o <= '0;
      data_o    <= '0;
      Valid_o   <= 1'b0;
      Err_o     <= 1'b0;
    end else begin
      Valid_o <= 1'b0;
      Err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (reject) begin
            Err_o <= 1'b1;
          end else if (Push_i) begin
            MemData_o <= data_i;
            RowSel_o  <= DEPTH'(1) << idx;
            WEn_o     <= 1'b1;
            state     <= WRITE;
          end else if (Pop_i) begin
            RowSel_o <= DEPTH'(1) << idx_dec;
            WEn_o    <= 1'b0;
            state    <= READ;
          end
        end
        WRITE: begin
          sp       <= sp + 1'b1;
          RowSel_o <= '0;
          WEn_o    <= 1'b0;
          state    <= IDLE;
        end
        READ: begin
          data_o   <= MemData_i;
          Valid_o  <= 1'b1;
          sp       <= sp - 1'b1;
          RowSel_o <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed tests of stack_ctrl against a behavioural word array.
module tb_stack_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0, pop = 1'b0;
  logic [7:0]  din = '0, dout, mem_wdata, mem_rdata;
  logic        valid, busy, full, empty, err, wen;
  logic [15:0] row_sel;
  logic [7:0]  mem [16];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .Clk_i(clk), .RstN_i(rst_n), .Push_i(push), .Pop_i(pop), .data_i(din),
    .data_o(dout), .Valid_o(valid), .Busy_o(busy), .Full_o(full), .Empty_o(empty),
    .Err_o(err), .RowSel_o(row_sel), .WEn_o(wen), .MemData_o(mem_wdata), .MemData_i(mem_rdata)
  );

  // word array: rows written on the clock edge, read data is the OR of selected rows
  always @(posedge clk)
    for (int r = 0; r < 16; r++) if (wen && row_sel[r]) mem[r] <= mem_wdata;
  always_comb begin
    mem_rdata = '0;
    for (int r = 0; r < 16; r++) if (row_sel[r]) mem_rdata = mem_rdata | mem[r];
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_push(input logic [7:0] d, input logic [15:0] exp_row);
    push = 1'b1; din = d;
    step();
    push = 1'b0;
    checks++; if (wen !== 1'b1 || row_sel !== exp_row || mem_wdata !== d || busy !== 1'b1) begin
      errors++; $display("FAIL push_write wen=%b row=%h wdata=%h busy=%b want wen=1 row=%h wdata=%h busy=1", wen, row_sel, mem_wdata, busy, exp_row, d);
    end
    step();
  endtask

  task automatic do_pop(input logic [7:0] exp_d, input logic [15:0] exp_row);
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (wen !== 1'b0 || row_sel !== exp_row || busy !== 1'b1) begin
      errors++; $display("FAIL pop_read wen=%b row=%h busy=%b want wen=0 row=%h busy=1", wen, row_sel, busy, exp_row);
    end
    step();
    checks++; if (valid !== 1'b1 || dout !== exp_d) begin
      errors++; $display("FAIL pop_data valid=%b data=%h want valid=1 data=%h", valid, dout, exp_d);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({row_sel, wen, mem_wdata, dout, valid, err, busy, empty, full} !== {16'h0, 1'b0, 8'h0, 8'h0, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL reset_state row=%h wen=%b wdata=%h data=%h valid=%b err=%b busy=%b empty=%b full=%b", row_sel, wen, mem_wdata, dout, valid, err, busy, empty, full);
    end
    step(); rst_n = 1'b1; step();
  endtask

  task automatic test_pop_empty();
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (err !== 1'b1 || empty !== 1'b1 || row_sel !== 16'h0 || wen !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL pop_empty err=%b empty=%b row=%h wen=%b busy=%b want 1 1 0000 0 0", err, empty, row_sel, wen, busy);
    end
    step();
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL err_pulse err=%b want 0", err);
    end
  endtask

  task automatic test_push_pop();
    do_push(8'hA5, 16'h0001);
    checks++; if (empty !== 1'b0) begin
      errors++; $display("FAIL not_empty empty=%b want 0", empty);
    end
    do_push(8'h3C, 16'h0002);
    do_pop(8'h3C, 16'h0002);
    do_pop(8'hA5, 16'h0001);
    checks++; if (empty !== 1'b1 || valid !== 1'b1) begin
      errors++; $display("FAIL empty_again empty=%b valid=%b want 1 1", empty, valid);
    end
    step();
    checks++; if (valid !== 1'b0 || dout !== 8'hA5) begin
      errors++; $display("FAIL valid_pulse valid=%b data=%h want 0 a5", valid, dout);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) do_push(8'(i), 16'(1) << i);
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL full full=%b empty=%b want 1 0", full, empty);
    end
    push = 1'b1; din = 8'hEE;
    step();
    push = 1'b0;
    checks++; if (err !== 1'b1 || wen !== 1'b0 || busy !== 1'b0 || full !== 1'b1) begin
      errors++; $display("FAIL push_full err=%b wen=%b busy=%b full=%b want 1 0 0 1", err, wen, busy, full);
    end
    step();
    for (int i = 15; i >= 0; i--) do_pop(8'(i), 16'(1) << i);
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL drained empty=%b full=%b want 1 0", empty, full);
    end
    step();
  endtask

  task automatic test_push_and_pop();
    do_push(8'h11, 16'h0001);
    do_push(8'h22, 16'h0002);
    do_push(8'h33, 16'h0004);
    push = 1'b1; pop = 1'b1; din = 8'h99;
    step();
    push = 1'b0; pop = 1'b0;
    checks++; if (err !== 1'b1 || wen !== 1'b0 || busy !== 1'b0 || row_sel !== 16'h0) begin
      errors++; $display("FAIL push_and_pop err=%b wen=%b busy=%b row=%h want 1 0 0 0000", err, wen, busy, row_sel);
    end
    step();
    do_pop(8'h33, 16'h0004);
  endtask

  task automatic test_back_to_back();
    int writes = 0, errs = 0;
    push = 1'b1; din = 8'h77;
    for (int c = 0; c < 4; c++) begin
      step();
      if (wen) writes++;
      if (err) errs++;
      if (c == 2) begin
        checks++; if (row_sel !== 16'h0008 || wen !== 1'b1) begin
          errors++; $display("FAIL held_second_row row=%h wen=%b want 0008 1", row_sel, wen);
        end
      end
    end
    push = 1'b0;
    checks++; if (writes !== 2 || errs !== 0) begin
      errors++; $display("FAIL held_push writes=%0d errs=%0d want 2 0", writes, errs);
    end
    do_pop(8'h77, 16'h0008);
  endtask

  task automatic test_reset_mid_write();
    do_push(8'h44, 16'h0008);
    do_push(8'h55, 16'h0010);
    push = 1'b1; din = 8'h66;
    step();
    push = 1'b0;
    checks++; if (wen !== 1'b1 || row_sel !== 16'h0020) begin
      errors++; $display("FAIL write_at_5 wen=%b row=%h want 1 0020", wen, row_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wen !== 1'b0 || row_sel !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_abort wen=%b row=%h busy=%b want 0 0000 0", wen, row_sel, busy);
    end
    step(); rst_n = 1'b1; step();
    checks++; if (empty !== 1'b1 || dout !== 8'h00 || full !== 1'b0) begin
      errors++; $display("FAIL after_reset empty=%b data=%h full=%b want 1 00 0", empty, dout, full);
    end
  endtask

  initial begin
    test_reset();
    test_pop_empty();
    test_push_pop();
    test_fill();
    test_push_and_pop();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
